// File: rtl/apl_l2_uram_rd_pkg.sv
// Shared constants, types and helpers for the per-channel L2 URAM read stage.
// Every other file of this block imports this package.
package apl_l2_uram_rd_pkg;

  localparam int unsigned L2NStrms  = 16;
  localparam int unsigned L2NStrmsW = $clog2(L2NStrms);
  localparam int unsigned L2Ncl     = 256;
  localparam int unsigned L2NclW    = $clog2(L2Ncl);
  localparam int unsigned UramLat   = 3;
  localparam int unsigned Depth     = 4;
  localparam int unsigned CredW     = $clog2(Depth + 1);
  localparam int unsigned UramAw    = L2NStrmsW + L2NclW;

  typedef logic [L2NStrmsW-1:0] sid_t;
  typedef logic [L2NclW-1:0]    ptr_t;
  typedef logic [L2NStrms-1:0]  strm_vec_t;
  typedef logic [CredW-1:0]     cred_t;

  // The sid field is the upper part, so the packed value is sid*L2Ncl + ptr.
  typedef struct packed {
    sid_t sid;
    ptr_t ptr;
  } l2_rd_t;

  function automatic strm_vec_t base_decode_le(input sid_t sid, input logic en);
    strm_vec_t vec;
    vec = '0;
    if (en) vec[sid] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/apl_l2_uram_rd_if.sv
// Request, URAM and response signals of one L2 read channel.
// The master modport is the upstream/consumer side; the slave modport is the read stage.
interface apl_l2_uram_rd_if;
  import apl_l2_uram_rd_pkg::*;

  logic              addr_v;
  logic              addr_r;
  sid_t              addr_sid;
  ptr_t              addr_ptr;
  logic              uram_re;
  logic [UramAw-1:0] uram_addr;
  strm_vec_t         rsp_v;
  strm_vec_t         rsp_r;
  sid_t              rsp_sid;
  cred_t             credits;

  modport master (
    output addr_v, addr_sid, addr_ptr, rsp_r,
    input  addr_r, uram_re, uram_addr, rsp_v, rsp_sid, credits
  );

  modport slave (
    input  addr_v, addr_sid, addr_ptr, rsp_r,
    output addr_r, uram_re, uram_addr, rsp_v, rsp_sid, credits
  );

endinterface

// File: rtl/apl_l2_uram_rd_fifo.sv
// Depth-entry stream-id FIFO holding responses whose URAM data has arrived.
// The head is read straight from registered storage.
module apl_l2_uram_rd_fifo
  import apl_l2_uram_rd_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  sid_t push_sid_i,
  input  logic pop_i,
  output logic empty_o,
  output logic full_o,
  output sid_t head_sid_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  sid_t            mem_q [Depth];
  sid_t            mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  cred_t           count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == cred_t'(Depth));
  assign head_sid_o = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_sid_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + cred_t'(1);
      2'b01:   count_d = count_q - cred_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Credits bound the reads in flight, so the FIFO can never overflow or underflow.
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));

endmodule

// File: rtl/apl_l2_uram_rd.sv
// Per-channel L2 read stage: credit-gated request accept, registered URAM read port,
// fixed-latency delay line and an in-order one-hot response queue.
module apl_l2_uram_rd
  import apl_l2_uram_rd_pkg::*;
(
  input logic              clk,
  input logic              reset,
  apl_l2_uram_rd_if.slave  bus
);

  cred_t     credits_q, credits_d;
  logic      uram_re_q, uram_re_d;
  l2_rd_t    uram_addr_q, uram_addr_d;
  logic      dl_v_q [UramLat];
  logic      dl_v_d [UramLat];
  sid_t      dl_sid_q [UramLat];
  sid_t      dl_sid_d [UramLat];

  logic      accept;
  logic      pop;
  logic      fifo_empty;
  logic      fifo_full;
  sid_t      head_sid;
  strm_vec_t rsp_v;

  // Ready comes only from the credit register; reset is gated in so ready stays low during reset.
  assign bus.addr_r = (credits_q != '0) && !reset;
  assign accept     = bus.addr_v && bus.addr_r;

  assign rsp_v = base_decode_le(head_sid, !fifo_empty);
  assign pop   = |(rsp_v & bus.rsp_r);

  assign bus.uram_re   = uram_re_q;
  assign bus.uram_addr = uram_addr_q;
  assign bus.rsp_v     = rsp_v;
  assign bus.rsp_sid   = head_sid;
  assign bus.credits   = credits_q;

  always_comb begin
    credits_d   = credits_q;
    uram_re_d   = accept;
    uram_addr_d = uram_addr_q;
    if (accept) begin
      uram_addr_d = '{sid: bus.addr_sid, ptr: bus.addr_ptr};
    end
    unique case ({accept, pop})
      2'b10:   credits_d = credits_q - cred_t'(1);
      2'b01:   credits_d = credits_q + cred_t'(1);
      default: credits_d = credits_q;
    endcase
  end

  // Stage 0 follows the URAM read-enable register, so the last stage lines up with read data.
  always_comb begin
    dl_v_d      = dl_v_q;
    dl_sid_d    = dl_sid_q;
    dl_v_d[0]   = uram_re_q;
    dl_sid_d[0] = uram_addr_q.sid;
    for (int i = 1; i < UramLat; i++) begin
      dl_v_d[i]   = dl_v_q[i-1];
      dl_sid_d[i] = dl_sid_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits_q   <= cred_t'(Depth);
      uram_re_q   <= 1'b0;
      uram_addr_q <= '0;
      dl_v_q      <= '{default: 1'b0};
      dl_sid_q    <= '{default: '0};
    end else begin
      credits_q   <= credits_d;
      uram_re_q   <= uram_re_d;
      uram_addr_q <= uram_addr_d;
      dl_v_q      <= dl_v_d;
      dl_sid_q    <= dl_sid_d;
    end
  end

  apl_l2_uram_rd_fifo u_rsp_fifo (
    .clk_i      (clk),
    .rst_i      (reset),
    .push_i     (dl_v_q[UramLat-1]),
    .push_sid_i (dl_sid_q[UramLat-1]),
    .pop_i      (pop),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .head_sid_o (head_sid)
  );

  a_credits_max: assert property (@(posedge clk) disable iff (reset) credits_q <= cred_t'(Depth));

endmodule

// File: tb/tb_apl_l2_uram_rd.sv
// Self-checking bench for apl_l2_uram_rd against a transaction-level model:
// each accepted read becomes visible UramLat+2 cycles later and leaves in accept order.
module tb_apl_l2_uram_rd;
  import apl_l2_uram_rd_pkg::*;

  localparam int RspLat = UramLat + 2;

  typedef struct {
    int sid;
    int ptr;
    int acc_cyc;
  } txn_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  apl_l2_uram_rd_if bus ();

  apl_l2_uram_rd u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_chk = 0;
  int   n_err = 0;
  txn_t q[$];
  int   cyc = 0;
  bit   exp_re = 1'b0;
  int   exp_addr = 0;
  int   dut_pops = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive at posedge+1, check at negedge, advance the model at the next posedge.
  task automatic step(input bit v, input int sid, input int ptr, input logic [15:0] r,
                      output bit acc);
    int credits;
    bit hv;
    int hs;
    bit pop;
    bus.addr_v   = v;
    bus.addr_sid = sid_t'(sid);
    bus.addr_ptr = ptr_t'(ptr);
    bus.rsp_r    = r;
    @(negedge clk);
    credits = Depth - q.size();
    hv      = (q.size() > 0) && (q[0].acc_cyc + RspLat <= cyc);
    hs      = hv ? q[0].sid : 0;
    chk("addr_r", {31'd0, bus.addr_r}, {31'd0, credits != 0});
    chk("credits", 32'(bus.credits), credits);
    chk("uram_re", {31'd0, bus.uram_re}, {31'd0, exp_re});
    if (exp_re) chk("uram_addr", 32'(bus.uram_addr), exp_addr);
    chk("rsp_v", 32'(bus.rsp_v), hv ? (32'd1 << hs) : 32'd0);
    if (hv) chk("rsp_sid", 32'(bus.rsp_sid), hs);
    if (|(bus.rsp_v & r)) dut_pops++;
    acc = v && (credits != 0);
    pop = hv && r[hs];
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back('{sid: sid, ptr: ptr, acc_cyc: cyc});
    exp_re   = acc;
    exp_addr = sid * L2Ncl + ptr;
    cyc++;
  endtask

  task automatic apply_reset(input int ncyc);
    reset       = 1'b1;
    bus.addr_v  = 1'b0;
    bus.rsp_r   = '1;
    q.delete();
    exp_re = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      chk("rst_rsp_v", 32'(bus.rsp_v), 0);
      chk("rst_uram_re", {31'd0, bus.uram_re}, 0);
      chk("rst_addr_r", {31'd0, bus.addr_r}, 0);
      @(posedge clk);
      #1;
      cyc++;
    end
    reset = 1'b0;
  endtask

  task automatic idle(input int ncyc, input logic [15:0] r);
    bit acc;
    for (int i = 0; i < ncyc; i++) step(1'b0, 0, 0, r, acc);
  endtask

  initial begin
    bit acc;
    int n_acc;
    int idx;
    bit pend;
    int psid;
    int pptr;
    int pops0;

    reset        = 1'b1;
    bus.addr_v   = 1'b0;
    bus.addr_sid = '0;
    bus.addr_ptr = '0;
    bus.rsp_r    = '1;
    @(posedge clk);
    #1;

    // Reset held, then ready and full credits after release.
    apply_reset(25);
    idle(2, 16'hFFFF);

    // Single read with all ready.
    step(1'b1, 1, 16'h10, 16'hFFFF, acc);
    idle(8, 16'hFFFF);

    // Credit stall: sids 0..5 offered back to back, nothing consumed.
    idx = 0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, idx, idx + 8'h20, 16'h0000, acc);
      if (acc) begin
        idx++;
        n_acc++;
      end
    end
    chk("stall_accepts", n_acc, 4);
    step(1'b1, idx, idx + 8'h20, 16'h0001, acc);
    if (acc) begin idx++; n_acc++; end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, idx, idx + 8'h20, 16'h0000, acc);
      if (acc) begin idx++; n_acc++; end
    end
    chk("stall_after_pop", n_acc, 5);
    idle(15, 16'hFFFF);

    // Head-of-line blocking: only stream 7 ready while stream 3 is at the head.
    step(1'b1, 3, 1, 16'hFFFF, acc);
    step(1'b1, 7, 2, 16'hFFFF, acc);
    step(1'b1, 3, 3, 16'hFFFF, acc);
    idle(10, 16'h0080);
    idle(6, 16'hFFFF);

    // Sustained traffic with everything ready.
    n_acc = 0;
    pops0 = dut_pops;
    for (int i = 0; i < 400 && n_acc < 100; i++) begin
      psid = $urandom_range(L2NStrms - 1);
      pptr = $urandom_range(L2Ncl - 1);
      do begin
        step(1'b1, psid, pptr, 16'hFFFF, acc);
        i++;
      end while (!acc && i < 400);
      if (acc) n_acc++;
    end
    chk("stream_accepts", n_acc, 100);
    idle(12, 16'hFFFF);
    chk("stream_pops", dut_pops - pops0, 100);

    // Random valid and random per-stream ready, holding a request until accepted.
    pend = 1'b0;
    psid = 0;
    pptr = 0;
    for (int i = 0; i < 300; i++) begin
      if (!pend && ($urandom_range(3) != 0)) begin
        pend = 1'b1;
        psid = $urandom_range(L2NStrms - 1);
        pptr = $urandom_range(L2Ncl - 1);
      end
      step(pend, psid, pptr, 16'($urandom), acc);
      if (acc) pend = 1'b0;
    end
    idle(40, 16'hFFFF);

    // Reset with reads in flight: everything is discarded immediately.
    step(1'b1, 5, 8'h11, 16'hFFFF, acc);
    step(1'b1, 6, 8'h22, 16'hFFFF, acc);
    step(1'b1, 9, 8'h33, 16'hFFFF, acc);
    reset = 1'b1;
    #1;
    chk("midrst_rsp_v", 32'(bus.rsp_v), 0);
    chk("midrst_uram_re", {31'd0, bus.uram_re}, 0);
    @(posedge clk);
    #1;
    cyc++;
    apply_reset(3);
    idle(12, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
